// File: rtl/psk_frame_pkg.sv
// rtl/psk_frame_pkg.sv - sync word, sync length and state encoding shared by the PSK framer and deframer
package psk_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hEB90;
    localparam int          SYNC_LEN          = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frame_state_t;

endpackage

// File: rtl/sync_correlator.sv
// rtl/sync_correlator.sv - Hamming distance between a sync window and a pattern, thresholded at MAX_ERR
module sync_correlator
    import psk_frame_pkg::*;
#(
    parameter int MAX_ERR = 1
) (
    input  logic [SYNC_LEN-1:0] window,
    input  logic [SYNC_LEN-1:0] pattern,
    output logic                match
);

    logic [SYNC_LEN-1:0] diff;
    logic [4:0]          distance;

    always_comb begin
        diff     = window ^ pattern;
        distance = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            distance = distance + {4'd0, diff[i]};
        end
        match = (distance <= 5'(MAX_ERR));
    end

endmodule

// File: rtl/rx_frame_deframer.sv
// rtl/rx_frame_deframer.sv - sync-word acquisition, polarity resolution and byte packing with flywheel lock
module rx_frame_deframer
    import psk_frame_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          MAX_ERR       = 1,
    parameter int          MISS_LIMIT    = 3
) (
    input  logic        clk_16M384,
    input  logic        rst_16M384,
    input  logic        bit_in,
    input  logic        bit_vld,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    output logic        data_tlast,
    output logic        data_tuser,
    output logic        frame_lock,
    output logic        polarity_inv,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] LAST_BYTE  = 8'(PAYLOAD_BYTES - 1);
    localparam logic [3:0] MISS_MAX   = 4'(MISS_LIMIT);
    localparam logic [3:0] CHECK_LAST = 4'(SYNC_LEN - 1);

    frame_state_t state, state_next;

    logic [15:0] sr, sr_next;
    logic        pol_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  byte_cnt, byte_cnt_next;
    logic [6:0]  byte_sr, byte_sr_next;
    logic [3:0]  chk_cnt, chk_cnt_next;
    logic [3:0]  miss_cnt, miss_cnt_next;
    logic [15:0] frame_cnt_next;
    logic [7:0]  tdata_next;
    logic        tvalid_next, tlast_next, tuser_next;
    logic        pos_match, neg_match, stored_match, payload_bit;

    // Correlators look at the window including the bit arriving this cycle.
    assign sr_next      = bit_vld ? {sr[14:0], bit_in} : sr;
    assign payload_bit  = bit_in ^ polarity_inv;
    assign stored_match = polarity_inv ? neg_match : pos_match;
    assign frame_lock   = (state != SEARCH);

    sync_correlator #(.MAX_ERR(MAX_ERR)) u_corr_pos (
        .window  (sr_next),
        .pattern (SYNC_WORD),
        .match   (pos_match)
    );

    sync_correlator #(.MAX_ERR(MAX_ERR)) u_corr_neg (
        .window  (sr_next),
        .pattern (~SYNC_WORD),
        .match   (neg_match)
    );

    always_comb begin
        state_next     = state;
        pol_next       = polarity_inv;
        bit_cnt_next   = bit_cnt;
        byte_cnt_next  = byte_cnt;
        byte_sr_next   = byte_sr;
        chk_cnt_next   = chk_cnt;
        miss_cnt_next  = miss_cnt;
        frame_cnt_next = frame_cnt;
        tdata_next     = data_tdata;
        tvalid_next    = 1'b0;
        tlast_next     = 1'b0;
        tuser_next     = 1'b0;

        if (bit_vld) begin
            case (state)
                SEARCH: begin
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                    if (pos_match) begin
                        pol_next   = 1'b0;
                        state_next = PAYLOAD;
                    end else if (neg_match) begin
                        pol_next   = 1'b1;
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    byte_sr_next = {byte_sr[5:0], payload_bit};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        tdata_next  = {byte_sr, payload_bit};
                        tvalid_next = 1'b1;
                        tuser_next  = (byte_cnt == 8'd0);
                        if (byte_cnt == LAST_BYTE) begin
                            tlast_next     = 1'b1;
                            frame_cnt_next = frame_cnt + 16'd1;
                            byte_cnt_next  = '0;
                            chk_cnt_next   = '0;
                            state_next     = CHECK;
                        end else begin
                            byte_cnt_next = byte_cnt + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    chk_cnt_next = chk_cnt + 4'd1;
                    if (chk_cnt == CHECK_LAST) begin
                        bit_cnt_next  = '0;
                        byte_cnt_next = '0;
                        // Only the polarity acquired in SEARCH counts; an inverted sync here is a miss.
                        if (stored_match) begin
                            miss_cnt_next = '0;
                            state_next    = PAYLOAD;
                        end else if (miss_cnt + 4'd1 >= MISS_MAX) begin
                            miss_cnt_next = '0;
                            pol_next      = 1'b0;
                            state_next    = SEARCH;
                        end else begin
                            miss_cnt_next = miss_cnt + 4'd1;
                            state_next    = PAYLOAD;
                        end
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            state        <= SEARCH;
            sr           <= '0;
            polarity_inv <= 1'b0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            byte_sr      <= '0;
            chk_cnt      <= '0;
            miss_cnt     <= '0;
            frame_cnt    <= '0;
            data_tdata   <= '0;
            data_tvalid  <= 1'b0;
            data_tlast   <= 1'b0;
            data_tuser   <= 1'b0;
        end else begin
            state        <= state_next;
            sr           <= sr_next;
            polarity_inv <= pol_next;
            bit_cnt      <= bit_cnt_next;
            byte_cnt     <= byte_cnt_next;
            byte_sr      <= byte_sr_next;
            chk_cnt      <= chk_cnt_next;
            miss_cnt     <= miss_cnt_next;
            frame_cnt    <= frame_cnt_next;
            data_tdata   <= tdata_next;
            data_tvalid  <= tvalid_next;
            data_tlast   <= tlast_next;
            data_tuser   <= tuser_next;
        end
    end

endmodule

// File: tb/tb_rx_frame_deframer.sv
// tb/tb_rx_frame_deframer.sv - scoreboard bench for rx_frame_deframer against a bit-array reference model
`timescale 1ns/1ps
module tb_rx_frame_deframer;

    localparam logic [15:0] SYNC       = 16'hEB90;
    localparam int          PB         = 16;
    localparam int          MAX_ERR    = 1;
    localparam int          MISS_LIMIT = 3;

    logic        clk_16M384 = 1'b0;
    logic        rst_16M384 = 1'b1;
    logic        bit_in     = 1'b0;
    logic        bit_vld    = 1'b0;
    logic [7:0]  data_tdata;
    logic        data_tvalid, data_tlast, data_tuser, frame_lock, polarity_inv;
    logic [15:0] frame_cnt;

    rx_frame_deframer #(
        .SYNC_WORD     (SYNC),
        .PAYLOAD_BYTES (PB),
        .MAX_ERR       (MAX_ERR),
        .MISS_LIMIT    (MISS_LIMIT)
    ) dut (
        .clk_16M384   (clk_16M384),
        .rst_16M384   (rst_16M384),
        .bit_in       (bit_in),
        .bit_vld      (bit_vld),
        .data_tdata   (data_tdata),
        .data_tvalid  (data_tvalid),
        .data_tlast   (data_tlast),
        .data_tuser   (data_tuser),
        .frame_lock   (frame_lock),
        .polarity_inv (polarity_inv),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk_16M384 = ~clk_16M384;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    bit    stim[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_frames;
    bit    exp_lock, exp_pol;
    logic  prev_tvalid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented byte is popped and compared against the scoreboard.
    always @(negedge clk_16M384) begin
        if (!rst_16M384 && data_tvalid) begin
            check("tvalid_single_cycle", {31'd0, prev_tvalid}, 32'd0);
            check("byte_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                beat_t e;
                e = exp_q.pop_front();
                check("byte", {22'd0, data_tdata, data_tuser, data_tlast}, {22'd0, e});
            end
        end
        prev_tvalid <= rst_16M384 ? 1'b0 : data_tvalid;
    end

    // Reference: walk the whole bit array with the frame rules, starting from the post-reset state.
    task automatic run_model();
        int         i;
        bit         locked, pol;
        int         miss;
        logic [15:0] win, w;
        logic [7:0] v;
        i = 0; locked = 0; pol = 0; miss = 0; win = '0; exp_frames = 0;
        while (i < stim.size()) begin
            if (!locked) begin
                win = {win[14:0], stim[i]};
                i++;
                if ($countones(win ^ SYNC) <= MAX_ERR) begin
                    locked = 1; pol = 0;
                end else if ($countones(win ^ ~SYNC) <= MAX_ERR) begin
                    locked = 1; pol = 1;
                end
            end else begin
                for (int b = 0; b < PB; b++) begin
                    if (i + 8 > stim.size()) begin
                        i = stim.size();
                        break;
                    end
                    v = '0;
                    for (int k = 0; k < 8; k++) v = {v[6:0], stim[i + k] ^ pol};
                    exp_q.push_back('{v, b == 0, b == PB - 1});
                    i += 8;
                    if (b == PB - 1) exp_frames++;
                end
                if (i + 16 <= stim.size()) begin
                    w = '0;
                    for (int k = 0; k < 16; k++) w = {w[14:0], stim[i + k]};
                    i += 16;
                    if ($countones(w ^ (pol ? ~SYNC : SYNC)) <= MAX_ERR) begin
                        miss = 0;
                    end else begin
                        miss++;
                        if (miss == MISS_LIMIT) begin
                            locked = 0; pol = 0; miss = 0; win = w;
                        end
                    end
                end else begin
                    i = stim.size();
                end
            end
        end
        exp_lock = locked;
        exp_pol  = pol;
    endtask

    task automatic push_bits(input logic [15:0] val, input int n);
        for (int k = n - 1; k >= 0; k--) stim.push_back(val[k]);
    endtask

    task automatic push_frame(input logic [15:0] sync, input bit incr);
        push_bits(sync, 16);
        for (int b = 0; b < PB; b++) push_bits(incr ? 16'(b) : 16'($urandom_range(255, 0)), 8);
    endtask

    task automatic do_reset();
        rst_16M384 = 1'b1;
        bit_vld    = 1'b0;
        repeat (2) @(posedge clk_16M384);
        #1;
        exp_q.delete();
        rst_16M384 = 1'b0;
    endtask

    task automatic drive(input int gmin, input int gmax);
        foreach (stim[k]) begin
            bit_in  = stim[k];
            bit_vld = 1'b1;
            @(posedge clk_16M384);
            #1;
            bit_vld = 1'b0;
            repeat (int'($urandom_range(gmax, gmin)) - 1) begin
                @(posedge clk_16M384);
                #1;
            end
        end
        repeat (3) @(posedge clk_16M384);
        #1;
    endtask

    task automatic scenario(input string name, input int gmin, input int gmax);
        do_reset();
        run_model();
        drive(gmin, gmax);
        check({name, "_drained"}, exp_q.size(), 32'd0);
        check({name, "_frame_cnt"}, {16'd0, frame_cnt}, exp_frames);
        check({name, "_lock"}, {31'd0, frame_lock}, {31'd0, exp_lock});
        check({name, "_polarity"}, {31'd0, polarity_inv}, {31'd0, exp_pol});
        stim.delete();
    endtask

    initial begin
        logic [15:0] s;

        do_reset();
        @(negedge clk_16M384);
        check("reset_outputs", {5'd0, data_tdata, data_tvalid, data_tlast, data_tuser,
                                frame_lock, polarity_inv, frame_cnt}, 32'd0);

        push_frame(SYNC, 1);
        scenario("clean", 16, 16);
        check("clean_cnt_is_1", {16'd0, frame_cnt}, 32'd1);

        push_frame(SYNC, 1);
        foreach (stim[k]) stim[k] = !stim[k];
        scenario("inverted", 2, 5);
        check("inverted_pol_set", {31'd0, polarity_inv}, 32'd1);

        push_frame(16'hEB91, 1);
        scenario("sync_1err", 1, 3);
        check("sync_1err_cnt", {16'd0, frame_cnt}, 32'd1);

        push_frame(16'hEB93, 1);
        scenario("sync_2err", 1, 3);
        check("sync_2err_no_lock", {31'd0, frame_lock}, 32'd0);

        push_frame(SYNC, 1);
        push_frame(16'hEB93, 1);
        push_frame(16'hEB93, 1);
        push_frame(16'hEB93, 1);
        scenario("flywheel", 1, 4);
        check("flywheel_cnt", {16'd0, frame_cnt}, 32'd3);
        check("flywheel_dropped", {31'd0, frame_lock}, 32'd0);

        for (int f = 0; f < 3; f++) push_frame(SYNC, 0);
        scenario("back_to_back", 1, 1);
        check("back_to_back_cnt", {16'd0, frame_cnt}, 32'd3);

        // Reset partway through byte 5 of a frame, then a fresh frame.
        do_reset();
        push_bits(SYNC, 16);
        for (int b = 0; b < 5; b++) push_bits(16'(b), 8);
        push_bits(16'h0005, 3);
        run_model();
        drive(1, 2);
        check("pre_reset_lock", {31'd0, frame_lock}, 32'd1);
        rst_16M384 = 1'b1;
        @(posedge clk_16M384);
        #1;
        check("midframe_reset_outputs", {5'd0, data_tdata, data_tvalid, data_tlast, data_tuser,
                                         frame_lock, polarity_inv, frame_cnt}, 32'd0);
        check("midframe_drained", exp_q.size(), 32'd0);
        stim.delete();
        push_frame(SYNC, 0);
        scenario("after_reset", 1, 2);

        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 4; f++) begin
                s = SYNC;
                if (f > 0) begin
                    for (int e = int'($urandom_range(2, 0)); e > 0; e--) s[$urandom_range(15, 0)] ^= 1'b1;
                end
                push_frame(s, 0);
            end
            if ($urandom_range(1, 0) == 1) begin
                foreach (stim[k]) stim[k] = !stim[k];
            end
            scenario("random", 1, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
